// File: rtl/fpchk_pkg.sv
// fpchk_pkg: FSM states, class codes and sticky-flag indices for the operand exception checker.
package fpchk_pkg;
  typedef enum logic [1:0] {IDLE, CLASSIFY, RESPOND, WAIT_LOW} state_t;
  localparam logic [2:0] CLS_NORMAL  = 3'b000;
  localparam logic [2:0] CLS_SUBNORM = 3'b001;
  localparam logic [2:0] CLS_INF     = 3'b011;
  localparam logic [2:0] CLS_QNAN    = 3'b100;
  localparam logic [2:0] CLS_SNAN    = 3'b101;
  localparam logic [2:0] CLS_ZERO    = 3'b111;
  localparam int STK_ZERO    = 0;
  localparam int STK_SUBNORM = 1;
  localparam int STK_INF     = 2;
  localparam int STK_QNAN    = 3;
  localparam int STK_SNAN    = 4;
  function automatic logic [4:0] sticky_bit(input logic [2:0] c);
    return c == CLS_SNAN    ? 5'(1) << STK_SNAN :
           c == CLS_QNAN    ? 5'(1) << STK_QNAN :
           c == CLS_INF     ? 5'(1) << STK_INF :
           c == CLS_SUBNORM ? 5'(1) << STK_SUBNORM :
           c == CLS_ZERO    ? 5'(1) << STK_ZERO : 5'b0;
  endfunction
endpackage

// File: rtl/fp_classify.sv
// fp_classify: combinational IEEE-style operand classifier (class code and sign).
module fp_classify
  import fpchk_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 7
) (
  input  logic [EXP_W+MAN_W:0] operand,
  output logic [2:0]           cls,
  output logic                 sign
);
  logic [EXP_W-1:0] exp_f;
  logic [MAN_W-1:0] man_f;
  logic exp_zero, exp_max, man_zero;
  always_comb begin
    exp_f    = operand[EXP_W+MAN_W-1:MAN_W];
    man_f    = operand[MAN_W-1:0];
    sign     = operand[EXP_W+MAN_W];
    exp_zero = ~|exp_f;
    exp_max  = &exp_f;
    man_zero = ~|man_f;
    cls = exp_zero ? (man_zero ? CLS_ZERO : CLS_SUBNORM) :
          exp_max  ? (man_zero ? CLS_INF : man_f[MAN_W-1] ? CLS_QNAN : CLS_SNAN) :
          CLS_NORMAL;
  end
endmodule

// File: rtl/fp_exception_checker.sv
// fp_exception_checker: handshake-driven operand classifier; optional sticky
// per-class flags when FPCHK_STICKY_EN is defined.
module fp_exception_checker
  import fpchk_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 7
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [EXP_W+MAN_W:0] Data,
  input  logic                 Data_valid,
`ifdef FPCHK_STICKY_EN
  input  logic                 Sticky_clr,
`endif
  output logic [2:0]           AEXC,
  output logic                 SIGN,
  output logic                 ACK,
  output logic                 BUSY
`ifdef FPCHK_STICKY_EN
  ,
  output logic [4:0]           STICKY
`endif
);
  state_t state;
  logic [EXP_W+MAN_W:0] opnd;
  logic [2:0] cls;
  logic sgn;
  fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_classify (
    .operand(opnd),
    .cls    (cls),
    .sign   (sgn)
  );
  assign BUSY = state != IDLE;
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
      opnd  <= '0;
      AEXC  <= CLS_NORMAL;
      SIGN  <= 1'b0;
      ACK   <= 1'b0;
    end else begin
      ACK <= 1'b0;
      case (state)
        IDLE: if (Data_valid) begin
          opnd  <= Data;
          state <= CLASSIFY;
        end
        CLASSIFY: begin
          AEXC  <= cls;
          SIGN  <= sgn;
          ACK   <= 1'b1;
          state <= RESPOND;
        end
        RESPOND:  state <= WAIT_LOW;
        WAIT_LOW: if (!Data_valid) state <= IDLE;
        default:  state <= IDLE;
      endcase
    end
  end
`ifdef FPCHK_STICKY_EN
  // clear-then-set: a class flagged on the same edge as a clear survives
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) STICKY <= '0;
    else STICKY <= (Sticky_clr ? 5'b0 : STICKY) | (state == CLASSIFY ? sticky_bit(cls) : 5'b0);
  end
`endif
endmodule

// File: tb/tb_fp_exception_checker.sv
// tb_fp_exception_checker: directed scoreboard bench for 16-bit and 64-bit configurations.
module tb_fp_exception_checker;
  typedef struct packed {
    logic [2:0] cls;
    logic       sign;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] data = '0;
  logic        data_valid = 1'b0;
  logic        sticky_clr = 1'b0;
  logic [2:0]  aexc;
  logic        sign, ack, busy;
  logic [4:0]  sticky;
  logic [63:0] data_w = '0;
  logic        data_valid_w = 1'b0;
  logic [2:0]  aexc_w;
  logic        sign_w, ack_w, busy_w;
  logic [4:0]  sticky_w;
  exp_t        sb[$];
  int          n_assert = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  fp_exception_checker #(.EXP_W(8), .MAN_W(7)) dut (
    .CLK(clk), .RST(rst), .Data(data), .Data_valid(data_valid),
`ifdef FPCHK_STICKY_EN
    .Sticky_clr(sticky_clr),
`endif
    .AEXC(aexc), .SIGN(sign), .ACK(ack), .BUSY(busy)
`ifdef FPCHK_STICKY_EN
    , .STICKY(sticky)
`endif
  );

  fp_exception_checker #(.EXP_W(11), .MAN_W(52)) dut_w (
    .CLK(clk), .RST(rst), .Data(data_w), .Data_valid(data_valid_w),
`ifdef FPCHK_STICKY_EN
    .Sticky_clr(1'b0),
`endif
    .AEXC(aexc_w), .SIGN(sign_w), .ACK(ack_w), .BUSY(busy_w)
`ifdef FPCHK_STICKY_EN
    , .STICKY(sticky_w)
`endif
  );

`ifndef FPCHK_STICKY_EN
  assign sticky   = '0;
  assign sticky_w = '0;
`endif

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // scoreboard consumer: every ACK pulse must match the oldest expectation
  always @(negedge clk) begin
    if (ack === 1'b1) begin
      if (sb.size() == 0) begin
        n_assert++;
        n_fail++;
        $error("FAIL unexpected_ack: observed ack with empty scoreboard, required none");
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_aexc", 64'(aexc), 64'(e.cls));
        chk("sb_sign", 64'(sign), 64'(e.sign));
      end
    end
  end

  task automatic txn(input logic [15:0] d, input logic [2:0] c, input logic s,
                     input int hold, input logic clr);
    sb.push_back('{cls: c, sign: s});
    @(negedge clk);
    data = d;
    data_valid = 1'b1;
    @(posedge clk); #1;
    chk("busy_capture", 64'(busy), 64'(1));
    chk("ack_early", 64'(ack), 64'(0));
    data = ~d;
    sticky_clr = clr;
    @(posedge clk); #1;
    chk("ack_pulse", 64'(ack), 64'(1));
    chk("busy_classify", 64'(busy), 64'(1));
    sticky_clr = 1'b0;
    @(posedge clk); #1;
    chk("ack_drop", 64'(ack), 64'(0));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("ack_hold", 64'(ack), 64'(0));
      chk("busy_hold", 64'(busy), 64'(1));
    end
    data_valid = 1'b0;
    @(posedge clk); #1;
    chk("busy_idle", 64'(busy), 64'(0));
  endtask

  task automatic txn_w(input logic [63:0] d, input logic [2:0] c);
    @(negedge clk);
    data_w = d;
    data_valid_w = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("w_ack", 64'(ack_w), 64'(1));
    chk("w_aexc", 64'(aexc_w), 64'(c));
    chk("w_sign", 64'(sign_w), 64'(d[63]));
    data_valid_w = 1'b0;
    repeat (2) @(posedge clk);
    #1 chk("w_busy_idle", 64'(busy_w), 64'(0));
  endtask

  initial begin
    #12;
    chk("rst_aexc", 64'(aexc), 64'(0));
    chk("rst_sign", 64'(sign), 64'(0));
    chk("rst_ack", 64'(ack), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_sticky", 64'(sticky), 64'(0));
    @(negedge clk) rst = 1'b0;
    txn(16'h3F80, 3'b000, 1'b0, 0, 1'b0);
    txn(16'h7F80, 3'b011, 1'b0, 0, 1'b0);
    txn(16'hFF80, 3'b011, 1'b1, 0, 1'b0);
    txn(16'h7FC0, 3'b100, 1'b0, 0, 1'b0);
    txn(16'h7F81, 3'b101, 1'b0, 0, 1'b0);
`ifdef FPCHK_STICKY_EN
    chk("sticky_nan_inf", 64'(sticky), 64'(5'b11100));
`endif
    txn(16'h0001, 3'b001, 1'b0, 0, 1'b0);
`ifdef FPCHK_STICKY_EN
    chk("sticky_sub", 64'(sticky), 64'(5'b11110));
    txn(16'h0000, 3'b111, 1'b0, 0, 1'b1);
    chk("sticky_clr_set", 64'(sticky), 64'(5'b00001));
`endif
    txn(16'h8000, 3'b111, 1'b1, 0, 1'b0);
    txn(16'h0001, 3'b001, 1'b0, 10, 1'b0);
    // reset while the 7F80 operand is in CLASSIFY: no ACK, outputs back to reset
    @(negedge clk);
    data = 16'h7F80;
    data_valid = 1'b1;
    @(posedge clk); #1;
    chk("pre_rst_busy", 64'(busy), 64'(1));
    rst = 1'b1;
    #1;
    chk("midrst_ack", 64'(ack), 64'(0));
    chk("midrst_aexc", 64'(aexc), 64'(0));
    chk("midrst_busy", 64'(busy), 64'(0));
    @(posedge clk); #1;
    chk("midrst_ack_hold", 64'(ack), 64'(0));
    sb.push_back('{cls: 3'b011, sign: 1'b0});
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    chk("rerun_busy", 64'(busy), 64'(1));
    @(posedge clk); #1;
    chk("rerun_ack", 64'(ack), 64'(1));
    chk("rerun_aexc", 64'(aexc), 64'(3'b011));
    @(negedge clk) data_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk("rerun_idle", 64'(busy), 64'(0));
    txn_w(64'h7FF8_0000_0000_0000, 3'b100);
    txn_w(64'h0000_0000_0000_0001, 3'b001);
    txn_w(64'hFFF0_0000_0000_0000, 3'b011);
    @(negedge clk);
    chk("sb_empty", 64'(sb.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: observed no completion, required finish before 50000");
    $fatal(1, "timeout");
  end
endmodule
